// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between the
// instruction cache (ic) and data cache (dc); one transaction in flight at a time.
module mem_arbiter #(
    parameter int unsigned MEM_ADDR_BITS = 28,
    parameter int unsigned MEM_DATA_BITS = 128,
    parameter int unsigned READ_BEATS    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ic_req_valid,
    output logic                       ic_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
    input  logic                       ic_req_rw,
    input  logic                       ic_req_data_valid,
    output logic                       ic_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                       ic_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
    input  logic                       dc_req_valid,
    output logic                       dc_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
    input  logic                       dc_req_rw,
    input  logic                       dc_req_data_valid,
    output logic                       dc_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                       dc_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int unsigned CntW = $clog2(READ_BEATS) + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(READ_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StWdata, StRdresp} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;           // 0 = ic, 1 = dc
    logic            last_grant_q, last_grant_d;
    logic [CntW-1:0] count_q, count_d;

    logic                       any_req, win, sel;
    logic [MEM_ADDR_BITS-1:0]   sel_addr;
    logic                       sel_rw, sel_dvalid;
    logic [MEM_DATA_BITS-1:0]   sel_dbits;
    logic [MEM_DATA_BITS/8-1:0] sel_dmask;

    // dc wins when alone, or on a tie when ic had the previous grant
    always_comb begin
        any_req    = ic_req_valid | dc_req_valid;
        win        = dc_req_valid & (~ic_req_valid | ~last_grant_q);
        sel        = (state_q == StIdle) ? win : owner_q;
        sel_addr   = sel ? dc_req_addr       : ic_req_addr;
        sel_rw     = sel ? dc_req_rw         : ic_req_rw;
        sel_dvalid = sel ? dc_req_data_valid : ic_req_data_valid;
        sel_dbits  = sel ? dc_req_data_bits  : ic_req_data_bits;
        sel_dmask  = sel ? dc_req_data_mask  : ic_req_data_mask;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        unique case (state_q)
            StIdle: begin
                if (any_req && mem_req_ready) begin
                    owner_d      = win;
                    last_grant_d = win;
                    if (!sel_rw) begin
                        state_d = StRdresp;
                        count_d = '0;
                    end else if (!(sel_dvalid && mem_req_data_ready)) begin
                        state_d = StWdata;
                    end
                end
            end
            StWdata: begin
                if (sel_dvalid && mem_req_data_ready) state_d = StIdle;
            end
            StRdresp: begin
                if (mem_resp_valid) begin
                    if (count_q == LastBeat) begin
                        state_d = StIdle;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced low while reset is held so an abort is visible at once
    always_comb begin
        ic_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        ic_resp_valid      = 1'b0;
        ic_resp_data       = '0;
        dc_req_ready       = 1'b0;
        dc_req_data_ready  = 1'b0;
        dc_resp_valid      = 1'b0;
        dc_resp_data       = '0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        if (reset) begin
            ic_resp_data = mem_resp_data;
            dc_resp_data = mem_resp_data;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        mem_req_valid      = 1'b1;
                        mem_req_addr       = sel_addr;
                        mem_req_rw         = sel_rw;
                        mem_req_data_valid = sel_dvalid;
                        mem_req_data_bits  = sel_dbits;
                        mem_req_data_mask  = sel_dmask;
                        if (sel) begin
                            dc_req_ready      = mem_req_ready;
                            dc_req_data_ready = mem_req_data_ready;
                        end else begin
                            ic_req_ready      = mem_req_ready;
                            ic_req_data_ready = mem_req_data_ready;
                        end
                    end
                end
                StWdata: begin
                    mem_req_data_valid = sel_dvalid;
                    mem_req_data_bits  = sel_dbits;
                    mem_req_data_mask  = sel_dmask;
                    if (owner_q) dc_req_data_ready = mem_req_data_ready;
                    else         ic_req_data_ready = mem_req_data_ready;
                end
                StRdresp: begin
                    if (owner_q) dc_resp_valid = mem_resp_valid;
                    else         ic_resp_valid = mem_resp_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

endmodule
